// File: rtl/motor_pwm_ctrl_pkg.sv
// Shared definitions for the motor PWM sequencing controller.
//   state_t    : controller state, encoded IDLE=0, RUN=1, STOPPING=2, FAULT=3
//                (this encoding is visible on the state output).
//   MIN_PERIOD : smallest period a load may request; anything shorter is rejected.
package motor_pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/motor_pwm_shadow_reg.sv
// Pending/active configuration store for the three-phase PWM group.
// A load request is validated and clamped into the pending set. The pending
// set is copied into the active set when the controller signals a safe
// boundary, so downstream phases never observe a partially updated set.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   load                   capture request for the req_* inputs
//   req_period             requested period; must be >= MIN_PERIOD
//   req_deadband           requested deadband, clamped to period/2
//   req_duty_a/b/c         requested duties, clamped to period
//   boundary               the controller allows pending -> active this cycle
//   period, deadband       active values
//   duty_a/b/c             active duties
//   pending                a captured set is waiting to be applied
//   load_ack               one-cycle pulse when a pending set became active
//   load_err               one-cycle pulse when a load was rejected
//   cfg_valid              at least one set has been applied since reset
module motor_pwm_shadow_reg
  import motor_pwm_ctrl_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] req_period,
  input  logic [SIZE-1:0] req_deadband,
  input  logic [SIZE-1:0] req_duty_a,
  input  logic [SIZE-1:0] req_duty_b,
  input  logic [SIZE-1:0] req_duty_c,
  input  logic            boundary,
  output logic [SIZE-1:0] period,
  output logic [SIZE-1:0] deadband,
  output logic [SIZE-1:0] duty_a,
  output logic [SIZE-1:0] duty_b,
  output logic [SIZE-1:0] duty_c,
  output logic            pending,
  output logic            load_ack,
  output logic            load_err,
  output logic            cfg_valid
);

  logic [SIZE-1:0] pend_period;
  logic [SIZE-1:0] pend_deadband;
  logic [SIZE-1:0] pend_duty_a;
  logic [SIZE-1:0] pend_duty_b;
  logic [SIZE-1:0] pend_duty_c;

  logic load_ok;
  logic apply;

  function automatic logic [SIZE-1:0] clamp(input logic [SIZE-1:0] value,
                                            input logic [SIZE-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

  assign load_ok = load && (req_period >= SIZE'(MIN_PERIOD));
  assign apply   = boundary && pending;

  // NOTE: registered state uses non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_period   <= '0;
      pend_deadband <= '0;
      pend_duty_a   <= '0;
      pend_duty_b   <= '0;
      pend_duty_c   <= '0;
      period        <= '0;
      deadband      <= '0;
      duty_a        <= '0;
      duty_b        <= '0;
      duty_c        <= '0;
      pending       <= 1'b0;
      load_ack      <= 1'b0;
      load_err      <= 1'b0;
      cfg_valid     <= 1'b0;
    end else begin
      load_ack <= apply;
      load_err <= load && !load_ok;

      if (apply) begin
        period    <= pend_period;
        deadband  <= pend_deadband;
        duty_a    <= pend_duty_a;
        duty_b    <= pend_duty_b;
        duty_c    <= pend_duty_c;
        cfg_valid <= 1'b1;
      end

      // A load arriving together with an apply refills pending with the new
      // set; the old pending set is the one that moves to active.
      if (load_ok) begin
        pend_period   <= req_period;
        pend_deadband <= clamp(req_deadband, req_period >> 1);
        pend_duty_a   <= clamp(req_duty_a, req_period);
        pend_duty_b   <= clamp(req_duty_b, req_period);
        pend_duty_c   <= clamp(req_duty_c, req_period);
        pending       <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Sequencing and configuration controller for three motor PWM phases sharing
// one timebase. Owns the shared up-counter, the common enable and the
// IDLE/RUN/STOPPING/FAULT state machine; configuration storage lives in
// motor_pwm_shadow_reg.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  request RUN from IDLE (needs a valid configuration)
//   stop                   request a graceful stop at the end of the period
//   fault                  external fault level; forces FAULT
//   fault_clr              leave FAULT once fault is low
//   load                   capture req_* into the pending configuration
//   req_period, req_deadband, req_duty_a/b/c   requested configuration
//   counter                shared timebase, 0..period-1 while running
//   enable                 phases enabled (RUN or STOPPING)
//   period, deadband, duty_a/b/c   active configuration
//   pending, load_ack, load_err    configuration status
//   sync                   one-cycle pulse with counter==0 in RUN
//   state                  IDLE=0, RUN=1, STOPPING=2, FAULT=3
module motor_pwm_ctrl
  import motor_pwm_ctrl_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            fault,
  input  logic            fault_clr,
  input  logic            load,
  input  logic [SIZE-1:0] req_period,
  input  logic [SIZE-1:0] req_deadband,
  input  logic [SIZE-1:0] req_duty_a,
  input  logic [SIZE-1:0] req_duty_b,
  input  logic [SIZE-1:0] req_duty_c,
  output logic [SIZE-1:0] counter,
  output logic            enable,
  output logic [SIZE-1:0] period,
  output logic [SIZE-1:0] deadband,
  output logic [SIZE-1:0] duty_a,
  output logic [SIZE-1:0] duty_b,
  output logic [SIZE-1:0] duty_c,
  output logic            pending,
  output logic            load_ack,
  output logic            load_err,
  output logic            sync,
  output logic [1:0]      state
);

  state_t st;
  logic   cfg_valid;
  logic   running;
  logic   wrap;
  logic   boundary;

  assign running = (st == ST_RUN) || (st == ST_STOPPING);
  // Only meaningful while running; the active period is then at least 2.
  assign wrap    = (counter == period - SIZE'(1));

  // Stopped states take a new configuration immediately. A running timebase
  // only takes it at the wrap, and a fault at the wrap defers it to FAULT.
  assign boundary = (st == ST_IDLE) || (st == ST_FAULT) ||
                    (running && wrap && !fault);

  assign state = st;

  motor_pwm_shadow_reg #(
    .SIZE(SIZE)
  ) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .req_period   (req_period),
    .req_deadband (req_deadband),
    .req_duty_a   (req_duty_a),
    .req_duty_b   (req_duty_b),
    .req_duty_c   (req_duty_c),
    .boundary     (boundary),
    .period       (period),
    .deadband     (deadband),
    .duty_a       (duty_a),
    .duty_b       (duty_b),
    .duty_c       (duty_c),
    .pending      (pending),
    .load_ack     (load_ack),
    .load_err     (load_err),
    .cfg_valid    (cfg_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ST_IDLE;
      counter <= '0;
      enable  <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync <= 1'b0;
      if (fault) begin
        // Fault overrides every other request made in the same cycle.
        st      <= ST_FAULT;
        counter <= '0;
        enable  <= 1'b0;
      end else begin
        unique case (st)
          ST_IDLE: begin
            counter <= '0;
            if (start && cfg_valid) begin
              st     <= ST_RUN;
              enable <= 1'b1;
              sync   <= 1'b1;
            end
          end
          ST_RUN: begin
            enable  <= 1'b1;
            counter <= wrap ? '0 : counter + SIZE'(1);
            sync    <= wrap && !stop;
            if (stop) st <= ST_STOPPING;
          end
          ST_STOPPING: begin
            if (wrap) begin
              st      <= ST_IDLE;
              counter <= '0;
              enable  <= 1'b0;
            end else begin
              counter <= counter + SIZE'(1);
            end
          end
          ST_FAULT: begin
            counter <= '0;
            enable  <= 1'b0;
            if (fault_clr) st <= ST_IDLE;
          end
          default: begin
            st      <= ST_IDLE;
            counter <= '0;
            enable  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
